img_ctrl_param: RTL

IMG_CTRL_PARAM -- requirements
Module: img_ctrl_param

---
 rtl/img_ctrl_pkg.sv | 40 ++++
 rtl/img_win_alu.sv | 107 ++++++++++
 rtl/img_ctrl_param.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/img_ctrl_pkg.sv
// Shared definitions for the image window controller: opcodes, FSM state
// encoding and a decode helper for opcodes that rewrite the 2x2 window.
package img_ctrl_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_RELOAD  = 4'd0;
   localparam logic [OP_W-1:0] OP_UP      = 4'd1;
   localparam logic [OP_W-1:0] OP_DOWN    = 4'd2;
   localparam logic [OP_W-1:0] OP_LEFT    = 4'd3;
   localparam logic [OP_W-1:0] OP_RIGHT   = 4'd4;
   localparam logic [OP_W-1:0] OP_AVG     = 4'd5;
   localparam logic [OP_W-1:0] OP_MIRX    = 4'd6;
   localparam logic [OP_W-1:0] OP_MIRY    = 4'd7;
   localparam logic [OP_W-1:0] OP_WRITE   = 4'd8;
   localparam logic [OP_W-1:0] OP_RESETXY = 4'd9;
   localparam logic [OP_W-1:0] OP_ENH     = 4'd10;
   localparam logic [OP_W-1:0] OP_DEC     = 4'd11;
   localparam logic [OP_W-1:0] OP_THR     = 4'd12;
   localparam logic [OP_W-1:0] OP_INVTHR  = 4'd13;
   localparam logic [OP_W-1:0] OP_ROTCW   = 4'd14;
   localparam logic [OP_W-1:0] OP_NOP     = 4'd15;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_CMD  = 2'd1,
      ST_EXEC = 2'd2,
      ST_DUMP = 2'd3
   } state_e;

   // True for opcodes whose EXEC cycle writes the four window pixels back.
   function automatic logic op_writes_window(input logic [OP_W-1:0] op);
      case (op)
         OP_AVG, OP_MIRX, OP_MIRY, OP_ENH, OP_DEC,
         OP_THR, OP_INVTHR, OP_ROTCW: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/img_win_alu.sv
// Combinational 2x2 window operator.
// Ports: op_i opcode; tl_i/tr_i/bl_i/br_i current window pixels;
//        tl_o_c/tr_o_c/bl_o_c/br_o_c new window pixels; we_o_c write-back enable.
module img_win_alu
   import img_ctrl_pkg::*;
#(
   parameter int unsigned PIX_W = 8
) (
   input  logic [OP_W-1:0]  op_i,
   input  logic [PIX_W-1:0] tl_i,
   input  logic [PIX_W-1:0] tr_i,
   input  logic [PIX_W-1:0] bl_i,
   input  logic [PIX_W-1:0] br_i,
   output logic [PIX_W-1:0] tl_o_c,
   output logic [PIX_W-1:0] tr_o_c,
   output logic [PIX_W-1:0] bl_o_c,
   output logic [PIX_W-1:0] br_o_c,
   output logic             we_o_c
);

   localparam int unsigned     STEP_I  = 2**(PIX_W-2);
   localparam logic [PIX_W:0]  STEP    = (PIX_W+1)'(STEP_I);
   localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};
   localparam logic [PIX_W-1:0] PIX_MIN = {PIX_W{1'b0}};

   // Add STEP, clamping on carry-out.
   function automatic logic [PIX_W-1:0] enhance(input logic [PIX_W-1:0] p);
      logic [PIX_W:0] s;
      s = {1'b0, p} + STEP;
      return s[PIX_W] ? PIX_MAX : s[PIX_W-1:0];
   endfunction

   // Subtract STEP, clamping on borrow (borrow shows up in the extra MSB).
   function automatic logic [PIX_W-1:0] decrease(input logic [PIX_W-1:0] p);
      logic [PIX_W:0] d;
      d = {1'b0, p} - STEP;
      return d[PIX_W] ? PIX_MIN : d[PIX_W-1:0];
   endfunction

   function automatic logic [PIX_W-1:0] threshold(input logic [PIX_W-1:0] p,
                                                  input logic inv);
      return (p[PIX_W-1] ^ inv) ? PIX_MAX : PIX_MIN;
   endfunction

   logic [PIX_W+1:0] sum_c;
   logic [PIX_W-1:0] avg_c;

   assign sum_c = (PIX_W+2)'(tl_i) + (PIX_W+2)'(tr_i)
                + (PIX_W+2)'(bl_i) + (PIX_W+2)'(br_i);
   assign avg_c = sum_c[PIX_W+1:2];

   // Window rewrite; pixels pass through unchanged for non-image opcodes.
   always_comb begin
      tl_o_c = tl_i;
      tr_o_c = tr_i;
      bl_o_c = bl_i;
      br_o_c = br_i;
      we_o_c = op_writes_window(op_i);
      case (op_i)
         OP_AVG: begin
            tl_o_c = avg_c;
            tr_o_c = avg_c;
            bl_o_c = avg_c;
            br_o_c = avg_c;
         end
         OP_MIRX: begin
            tl_o_c = bl_i;
            bl_o_c = tl_i;
            tr_o_c = br_i;
            br_o_c = tr_i;
         end
         OP_MIRY: begin
            tl_o_c = tr_i;
            tr_o_c = tl_i;
            bl_o_c = br_i;
            br_o_c = bl_i;
         end
         OP_ROTCW: begin
            tl_o_c = bl_i;
            tr_o_c = tl_i;
            br_o_c = tr_i;
            bl_o_c = br_i;
         end
         OP_ENH: begin
            tl_o_c = enhance(tl_i);
            tr_o_c = enhance(tr_i);
            bl_o_c = enhance(bl_i);
            br_o_c = enhance(br_i);
         end
         OP_DEC: begin
            tl_o_c = decrease(tl_i);
            tr_o_c = decrease(tr_i);
            bl_o_c = decrease(bl_i);
            br_o_c = decrease(br_i);
         end
         OP_THR, OP_INVTHR: begin
            tl_o_c = threshold(tl_i, op_i == OP_INVTHR);
            tr_o_c = threshold(tr_i, op_i == OP_INVTHR);
            bl_o_c = threshold(bl_i, op_i == OP_INVTHR);
            br_o_c = threshold(br_i, op_i == OP_INVTHR);
         end
         OP_NOP: ;
         default: ;
      endcase
   end

endmodule

// File: rtl/img_ctrl_param.sv
// Image buffer controller: loads an IMG_W x IMG_H image in raster order,
// executes 2x2 window commands at a movable pointer, and dumps the image.
// Ports: clk/reset_n; in_valid/in_data/in_ready load stream;
//        cmd_valid/cmd/cmd_ready command port;
//        out_valid/out_data/out_addr/out_ready dump stream;
//        busy (not in CMD); x_ptr/y_ptr window bottom-right corner.
module img_ctrl_param
   import img_ctrl_pkg::*;
#(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned COL_BITS = 3,
   parameter int unsigned ROW_BITS = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   input  logic [PIX_W-1:0]             in_data,
   output logic                         in_ready,
   input  logic                         cmd_valid,
   input  logic [OP_W-1:0]              cmd,
   output logic                         cmd_ready,
   output logic                         out_valid,
   output logic [PIX_W-1:0]             out_data,
   output logic [ROW_BITS+COL_BITS-1:0] out_addr,
   input  logic                         out_ready,
   output logic                         busy,
   output logic [COL_BITS-1:0]          x_ptr,
   output logic [ROW_BITS-1:0]          y_ptr
);

   localparam int unsigned IMG_W  = 2**COL_BITS;
   localparam int unsigned IMG_H  = 2**ROW_BITS;
   localparam int unsigned ADDR_W = ROW_BITS + COL_BITS;
   localparam int unsigned N_PIX  = IMG_W * IMG_H;

   localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(N_PIX - 1);
   localparam logic [COL_BITS-1:0] X_MIN     = COL_BITS'(1);
   localparam logic [COL_BITS-1:0] X_MAX     = COL_BITS'(IMG_W - 1);
   localparam logic [COL_BITS-1:0] X_MID     = COL_BITS'(IMG_W / 2);
   localparam logic [ROW_BITS-1:0] Y_MIN     = ROW_BITS'(1);
   localparam logic [ROW_BITS-1:0] Y_MAX     = ROW_BITS'(IMG_H - 1);
   localparam logic [ROW_BITS-1:0] Y_MID     = ROW_BITS'(IMG_H / 2);

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     load_cnt_q, load_cnt_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [OP_W-1:0]       op_q, op_d;
   logic [COL_BITS-1:0]   x_q, x_d;
   logic [ROW_BITS-1:0]   y_q, y_d;
   logic                  in_ready_q, cmd_ready_q, out_valid_q, busy_q;
   logic [PIX_W-1:0]      out_data_q;
   logic                  load_we_c, win_we_c;

   logic [PIX_W-1:0]      img_q [N_PIX];

   logic [COL_BITS-1:0]   xm1_c;
   logic [ROW_BITS-1:0]   ym1_c;
   logic [ADDR_W-1:0]     a_tl_c, a_tr_c, a_bl_c, a_br_c;
   logic [PIX_W-1:0]      alu_tl_c, alu_tr_c, alu_bl_c, alu_br_c;
   logic                  alu_we_c;

   // Window addresses; pointers never drop below 1 so the -1 never wraps.
   assign xm1_c  = x_q - COL_BITS'(1);
   assign ym1_c  = y_q - ROW_BITS'(1);
   assign a_tl_c = {ym1_c, xm1_c};
   assign a_tr_c = {ym1_c, x_q};
   assign a_bl_c = {y_q,   xm1_c};
   assign a_br_c = {y_q,   x_q};

   img_win_alu #(
      .PIX_W (PIX_W)
   ) u_alu (
      .op_i   (op_q),
      .tl_i   (img_q[a_tl_c]),
      .tr_i   (img_q[a_tr_c]),
      .bl_i   (img_q[a_bl_c]),
      .br_i   (img_q[a_br_c]),
      .tl_o_c (alu_tl_c),
      .tr_o_c (alu_tr_c),
      .bl_o_c (alu_bl_c),
      .br_o_c (alu_br_c),
      .we_o_c (alu_we_c)
   );

   // Next-state, counters and pointer updates.
   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      addr_d     = addr_q;
      op_d       = op_q;
      x_d        = x_q;
      y_d        = y_q;
      load_we_c  = 1'b0;
      win_we_c   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               load_we_c  = 1'b1;
               load_cnt_d = load_cnt_q + ADDR_W'(1);
               if (load_cnt_q == LAST_ADDR) begin
                  state_d    = ST_CMD;
                  load_cnt_d = '0;
               end
            end
         end
         ST_CMD: begin
            if (cmd_valid) begin
               op_d       = cmd;
               addr_d     = '0;
               load_cnt_d = '0;
               case (cmd)
                  OP_WRITE:  state_d = ST_DUMP;
                  OP_RELOAD: state_d = ST_LOAD;
                  default:   state_d = ST_EXEC;
               endcase
            end
         end
         ST_EXEC: begin
            state_d  = ST_CMD;
            win_we_c = alu_we_c;
            case (op_q)
               OP_UP:    if (y_q > Y_MIN) y_d = y_q - ROW_BITS'(1);
               OP_DOWN:  if (y_q < Y_MAX) y_d = y_q + ROW_BITS'(1);
               OP_LEFT:  if (x_q > X_MIN) x_d = x_q - COL_BITS'(1);
               OP_RIGHT: if (x_q < X_MAX) x_d = x_q + COL_BITS'(1);
               OP_RESETXY: begin
                  x_d = X_MID;
                  y_d = Y_MID;
               end
               default: ;
            endcase
         end
         ST_DUMP: begin
            if (out_valid_q && out_ready) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_CMD;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Control state and registered outputs, decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_LOAD;
         load_cnt_q  <= '0;
         addr_q      <= '0;
         op_q        <= OP_NOP;
         x_q         <= X_MID;
         y_q         <= Y_MID;
         in_ready_q  <= 1'b1;
         cmd_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         addr_q      <= addr_d;
         op_q        <= op_d;
         x_q         <= x_d;
         y_q         <= y_d;
         in_ready_q  <= (state_d == ST_LOAD);
         cmd_ready_q <= (state_d == ST_CMD);
         out_valid_q <= (state_d == ST_DUMP);
         // Image is frozen while dumping, so reading at addr_d is stable.
         out_data_q  <= (state_d == ST_DUMP) ? img_q[addr_d] : '0;
         busy_q      <= (state_d != ST_CMD);
      end
   end

   // Pixel storage; deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_we_c) begin
         img_q[load_cnt_q] <= in_data;
      end
      if (win_we_c) begin
         img_q[a_tl_c] <= alu_tl_c;
         img_q[a_tr_c] <= alu_tr_c;
         img_q[a_bl_c] <= alu_bl_c;
         img_q[a_br_c] <= alu_br_c;
      end
   end

   assign in_ready  = in_ready_q;
   assign cmd_ready = cmd_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = addr_q;
   assign busy      = busy_q;
   assign x_ptr     = x_q;
   assign y_ptr     = y_q;

endmodule
